breath_ramp_gen: RTL

BREATH_RAMP_GEN -- requirements
Module: breath_ramp_gen

---
 rtl/breath_pkg.sv | 27 ++
 rtl/breath_tick_div.sv | 30 +++
 rtl/breath_ramp_gen.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/breath_pkg.sv
// Shared types and defaults for the breathing ramp generator.
// Optional build macro: BREATH_HOLD_EN adds dwell states at peak and trough.
package breath_pkg;

  localparam int DUTY_W         = 16;
  localparam int DEF_CLK_DIV    = 12000;
  localparam int DEF_MAX_DUTY   = 12000;
  localparam int DEF_STEP       = 1;
  localparam int DEF_HOLD_TICKS = 250;

`ifdef BREATH_HOLD_EN
  typedef enum logic [2:0] {
    IDLE,
    RISE,
    HOLD_HI,
    FALL,
    HOLD_LO
  } breath_state_e;
`else
  typedef enum logic [1:0] {
    IDLE,
    RISE,
    FALL
  } breath_state_e;
`endif

endpackage

// File: rtl/breath_tick_div.sv
// Ramp prescaler: counts 0..CLK_DIV-1 and pulses tick for one cycle at the top.
// Held at zero while clr is high so every enable starts a full period.
module breath_tick_div #(
  parameter int CLK_DIV = 12000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] L_TOP = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = (r_cnt == L_TOP) && !clr;

  // Free-running period counter, wraps on tick and clears while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/breath_ramp_gen.sv
// Triangle-wave duty generator for an LED "breathing" PWM stage.
// Optional build macro: BREATH_HOLD_EN adds HOLD_TICKS dwell at peak and trough.
//
// state   | meaning
// IDLE    | disabled, level 0
// RISE    | level climbs by STEP per accepted tick, saturating at MAX_DUTY
// HOLD_HI | dwell at MAX_DUTY (BREATH_HOLD_EN only)
// FALL    | level drops by STEP per accepted tick, floored at 0
// HOLD_LO | dwell at 0 (BREATH_HOLD_EN only)
module breath_ramp_gen
  import breath_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int MAX_DUTY   = DEF_MAX_DUTY,
  parameter int STEP       = DEF_STEP,
  parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  input  logic              duty_ready,
  output logic              overrun
);

  localparam int DW1 = DUTY_W + 1;
  localparam logic [DUTY_W:0]   L_MAX17 = DW1'(MAX_DUTY);
  localparam logic [DUTY_W-1:0] L_MAX   = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0] L_STEP  = DUTY_W'(STEP);

  breath_state_e     r_state, w_state_nxt;
  logic [DUTY_W-1:0] r_level, w_level_nxt;
  logic [DUTY_W-1:0] r_duty;
  logic              r_valid;
  logic              r_overrun;
  logic [DUTY_W:0]   w_sum;
  logic              w_tick, w_active, w_pending, w_tick_ok, w_drop, w_load;

`ifdef BREATH_HOLD_EN
  localparam logic [15:0] L_HOLD_LAST = 16'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);
  logic [15:0] r_hold_cnt, w_hold_nxt;
`endif

  breath_tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!en),
    .tick (w_tick)
  );

  // A tick is only usable once the previous duty value has been taken.
  assign w_active  = en && (r_state != IDLE);
  assign w_pending = r_valid && !duty_ready;
  assign w_tick_ok = w_tick && w_active && !w_pending;
  assign w_drop    = w_tick && w_active && w_pending;
  assign w_sum     = {1'b0, r_level} + {1'b0, L_STEP};

  assign duty       = r_duty;
  assign duty_valid = r_valid;
  assign overrun    = r_overrun;

  // Next-state, next-level and transfer-load decode.
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_load      = 1'b0;
`ifdef BREATH_HOLD_EN
    w_hold_nxt  = r_hold_cnt;
`endif
    if (!en) begin
      if (r_state != IDLE) begin
        w_state_nxt = IDLE;
        w_level_nxt = '0;
        w_load      = 1'b1;
      end
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = RISE;
          w_level_nxt = '0;
        end
        RISE: begin
          if (w_tick_ok) begin
            w_load = 1'b1;
            if (w_sum >= L_MAX17) begin
              w_level_nxt = L_MAX;
`ifdef BREATH_HOLD_EN
              w_state_nxt = HOLD_HI;
              w_hold_nxt  = '0;
`else
              w_state_nxt = FALL;
`endif
            end else begin
              w_level_nxt = w_sum[DUTY_W-1:0];
            end
          end
        end
        FALL: begin
          if (w_tick_ok) begin
            w_load = 1'b1;
            if (r_level <= L_STEP) begin
              w_level_nxt = '0;
`ifdef BREATH_HOLD_EN
              w_state_nxt = HOLD_LO;
              w_hold_nxt  = '0;
`else
              w_state_nxt = RISE;
`endif
            end else begin
              w_level_nxt = r_level - L_STEP;
            end
          end
        end
`ifdef BREATH_HOLD_EN
        HOLD_HI: begin
          if (w_tick_ok) begin
            if (r_hold_cnt >= L_HOLD_LAST) begin
              w_state_nxt = FALL;
              w_hold_nxt  = '0;
            end else begin
              w_hold_nxt = r_hold_cnt + 16'd1;
            end
          end
        end
        HOLD_LO: begin
          if (w_tick_ok) begin
            if (r_hold_cnt >= L_HOLD_LAST) begin
              w_state_nxt = RISE;
              w_hold_nxt  = '0;
            end else begin
              w_hold_nxt = r_hold_cnt + 16'd1;
            end
          end
        end
`endif
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Level, output handshake register and overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level   <= '0;
      r_duty    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_level   <= w_level_nxt;
      r_overrun <= w_drop;
      if (w_load) begin
        r_duty  <= w_level_nxt;
        r_valid <= 1'b1;
      end else if (r_valid && duty_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef BREATH_HOLD_EN
  // Dwell counter for the peak/trough hold states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else begin
      r_hold_cnt <= w_hold_nxt;
    end
  end
`endif

endmodule
